// File: rtl/conv_db_scheduler_pkg.sv
// conv_db_scheduler_pkg
//   Shared constants for the input double-buffer scheduler:
//   - FSM state encodings (3-bit, legacy-compatible localparams)
//   - field slot positions for the 10-field layer config bus and the
//     8-field address-generator config bus (slot 0 = least significant field)
package conv_db_scheduler_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CONFIG    = 3'd1;
  localparam logic [2:0] WAIT_FILL = 3'd2;
  localparam logic [2:0] SWITCH    = 3'd3;
  localparam logic [2:0] READ      = 3'd4;
  localparam logic [2:0] DRAIN     = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  localparam int NUM_CFG_FIELDS = 10;
  localparam int NUM_GEN_FIELDS = 8;

  // Layer config bus {OX0,OY0,FX,FY,STRIDE,IX0,IY0,IC1,OC1,NTILE}, MSB first.
  localparam int FLD_NTILE  = 0;
  localparam int FLD_OC1    = 1;
  localparam int FLD_IC1    = 2;
  localparam int FLD_IY0    = 3;
  localparam int FLD_IX0    = 4;
  localparam int FLD_STRIDE = 5;
  localparam int FLD_FY     = 6;
  localparam int FLD_FX     = 7;
  localparam int FLD_OY0    = 8;
  localparam int FLD_OX0    = 9;

  // The address-generator bus {OX0..IC1} is the upper eight layer fields,
  // so its slot k equals layer slot k + GEN_FIELD_BASE.
  localparam int GEN_FIELD_BASE = NUM_CFG_FIELDS - NUM_GEN_FIELDS;

  // LSB position of a field slot on a bus of the given field width.
  function automatic int fld_lsb(input int slot, input int width);
    return slot * width;
  endfunction

endpackage

// File: rtl/conv_db_scheduler_tile_loop_counter.sv
// tile_loop_counter
//   Wrapping loop counter. Counts inc pulses from 0 up to 'limit', then wraps
//   back to 0 on the next inc. 'last' is high while the count equals 'limit'.
//   Ports:
//     clk, rst_n  clock, synchronous active-low reset
//     clear       force count to 0 (has priority over inc)
//     inc         advance (wrapping) by one
//     limit       terminal count value
//     last        count == limit
module tile_loop_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic             last
);

  logic [WIDTH-1:0] count_q;

  assign last = (count_q == limit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= last ? '0 : count_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/conv_db_scheduler.sv
// conv_db_scheduler
//   Layer-level controller for the ifmap double buffer. Configures the read
//   address generator once per layer, then for every input tile waits for the
//   idle bank to fill, swaps banks and runs OC1 read passes of N enables each
//   (N = OX0*OY0*FX*FY*IC1), handing each finished output tile to the drain.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     start, config_data  layer start request and 10-field layer config
//     busy, done, cfg_err layer status / completion pulse / rejected config
//     ifmap_config_en/_data  one-shot config to the read-address generator
//     ifmap_bank_full     write side filled the idle bank (level)
//     bank_switch         swap read/write banks (pulse)
//     stall               datapath back-pressure, gates ifmap_radr_en
//     ifmap_radr_en       step the read-address generator
//     drain_start/_done   output tile handshake with the ofmap drain
module conv_db_scheduler
  import conv_db_scheduler_pkg::*;
#(
  parameter int BANK_ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [10*BANK_ADDR_WIDTH-1:0] config_data,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err,
  output logic                         ifmap_config_en,
  output logic [8*BANK_ADDR_WIDTH-1:0] ifmap_config_data,
  input  logic                         ifmap_bank_full,
  output logic                         bank_switch,
  input  logic                         stall,
  output logic                         ifmap_radr_en,
  output logic                         drain_start,
  input  logic                         drain_done
);

  localparam int W         = BANK_ADDR_WIDTH;
  localparam int CNT_WIDTH = 5 * BANK_ADDR_WIDTH;

  logic [2:0]            state_q;
  logic [10*W-1:0]       cfg_q;
  logic [CNT_WIDTH-1:0]  n_q;
  logic                  cfg_err_q;
  logic                  drain_start_q;

  logic                  cfg_ok;
  logic [CNT_WIDTH-1:0]  n_prod;
  logic                  rd_last, oc_last, tile_last;
  logic                  rd_clear, oc_clear, oc_inc, tile_clear, tile_inc;

  // Validity is judged on the incoming bus so a bad config is rejected in the
  // start cycle; IX0/IY0 may legitimately be 0.
  assign cfg_ok = (config_data[fld_lsb(FLD_OX0, W)    +: W] != '0) &&
                  (config_data[fld_lsb(FLD_OY0, W)    +: W] != '0) &&
                  (config_data[fld_lsb(FLD_FX, W)     +: W] != '0) &&
                  (config_data[fld_lsb(FLD_FY, W)     +: W] != '0) &&
                  (config_data[fld_lsb(FLD_STRIDE, W) +: W] != '0) &&
                  (config_data[fld_lsb(FLD_IC1, W)    +: W] != '0) &&
                  (config_data[fld_lsb(FLD_OC1, W)    +: W] != '0) &&
                  (config_data[fld_lsb(FLD_NTILE, W)  +: W] != '0);

  // Reads per pass; each factor is widened first so the product cannot wrap.
  assign n_prod = CNT_WIDTH'(cfg_q[fld_lsb(FLD_OX0, W) +: W]) *
                  CNT_WIDTH'(cfg_q[fld_lsb(FLD_OY0, W) +: W]) *
                  CNT_WIDTH'(cfg_q[fld_lsb(FLD_FX, W)  +: W]) *
                  CNT_WIDTH'(cfg_q[fld_lsb(FLD_FY, W)  +: W]) *
                  CNT_WIDTH'(cfg_q[fld_lsb(FLD_IC1, W) +: W]);

  assign busy              = (state_q != IDLE);
  assign done              = (state_q == DONE);
  assign cfg_err           = cfg_err_q;
  assign ifmap_config_en   = (state_q == CONFIG);
  assign ifmap_config_data = cfg_q[10*W-1 : fld_lsb(GEN_FIELD_BASE, W)];
  assign bank_switch       = (state_q == SWITCH);
  assign ifmap_radr_en     = (state_q == READ) && !stall;
  assign drain_start       = drain_start_q;

  // rd_cnt wraps to 0 on its own after N enables; clearing it in DRAIN only
  // restates that before the next pass.
  assign rd_clear   = (state_q == SWITCH) || (state_q == DRAIN);
  assign oc_clear   = (state_q == SWITCH);
  assign oc_inc     = (state_q == DRAIN) && drain_done && !oc_last;
  assign tile_clear = (state_q == CONFIG);
  assign tile_inc   = (state_q == DRAIN) && drain_done && oc_last && !tile_last;

  tile_loop_counter #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (rd_clear),
    .inc   (ifmap_radr_en),
    .limit (n_q - CNT_WIDTH'(1)),
    .last  (rd_last)
  );

  tile_loop_counter #(.WIDTH(W)) u_oc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (oc_clear),
    .inc   (oc_inc),
    .limit (cfg_q[fld_lsb(FLD_OC1, W) +: W] - W'(1)),
    .last  (oc_last)
  );

  tile_loop_counter #(.WIDTH(W)) u_tile_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tile_clear),
    .inc   (tile_inc),
    .limit (cfg_q[fld_lsb(FLD_NTILE, W) +: W] - W'(1)),
    .last  (tile_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cfg_q         <= '0;
      n_q           <= '0;
      cfg_err_q     <= 1'b0;
      drain_start_q <= 1'b0;
    end else begin
      cfg_err_q     <= 1'b0;
      drain_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cfg_q <= config_data;
            if (cfg_ok) state_q   <= CONFIG;
            else        cfg_err_q <= 1'b1;
          end
        end
        CONFIG: begin
          n_q     <= n_prod;
          state_q <= WAIT_FILL;
        end
        WAIT_FILL: begin
          if (ifmap_bank_full) state_q <= SWITCH;
        end
        SWITCH: begin
          state_q <= READ;
        end
        READ: begin
          if (ifmap_radr_en && rd_last) begin
            state_q       <= DRAIN;
            drain_start_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            if (!oc_last)        state_q <= READ;
            else if (!tile_last) state_q <= WAIT_FILL;
            else                 state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/conv_db_scheduler.md
Name: conv_db_scheduler

Overview:
- Layer-level controller for the input double buffer and its read-address generator.
- Configures the ifmap read-address generator once per layer.
- For each input tile: waits for the write side to fill the idle bank, swaps banks, then issues read-enable pulses for every output-channel tile (OC1 passes).
- Hands each finished output tile to the ofmap drain logic and signals layer completion.

Parameters:
- BANK_ADDR_WIDTH, 8, width of every config field and of the address-generator config bus.
- CNT_WIDTH, localparam = 5*BANK_ADDR_WIDTH, width of the per-pass read counter (product OX0*OY0*FX*FY*IC1 never overflows).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  one-cycle layer start request
- config_data  in  10*BANK_ADDR_WIDTH  {OX0,OY0,FX,FY,STRIDE,IX0,IY0,IC1,OC1,NTILE}, MSB first
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of layer
- cfg_err  out  1  one-cycle pulse when a config is rejected
- ifmap_config_en  out  1  one-cycle config strobe to address generator
- ifmap_config_data  out  8*BANK_ADDR_WIDTH  {OX0,OY0,FX,FY,STRIDE,IX0,IY0,IC1}
- ifmap_bank_full  in  1  write side has filled idle bank (level)
- bank_switch  out  1  one-cycle pulse: swap read/write banks
- stall  in  1  datapath back-pressure; suppresses read enable
- ifmap_radr_en  out  1  step ifmap read-address generator
- drain_start  out  1  one-cycle pulse: output tile ready to drain
- drain_done  in  1  one-cycle pulse from ofmap drain logic

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- Reset (and reset mid-operation): state=IDLE; all counters and latched config 0; busy, done, cfg_err, ifmap_config_en, bank_switch, ifmap_radr_en, drain_start all 0; ifmap_config_data 0.
- IDLE:
  - start=1 latches config_data.
  - If any of OX0,OY0,FX,FY,IC1,OC1,NTILE,STRIDE is 0: pulse cfg_err next cycle and stay IDLE (busy stays 0).
  - Otherwise go to CONFIG.
  - start outside IDLE is ignored.
- CONFIG (1 cycle):
  - ifmap_config_en=1; ifmap_config_data driven from latched fields.
  - N = OX0*OY0*FX*FY*IC1 computed (registered).
  - tile_cnt=0; go to WAIT_FILL.
- WAIT_FILL: hold until ifmap_bank_full=1, then go to SWITCH.
- SWITCH (1 cycle): bank_switch=1; oc_cnt=0; rd_cnt=0; go to READ.
- READ:
  - ifmap_radr_en = ~stall (combinational from state and stall).
  - rd_cnt increments on each cycle with ifmap_radr_en=1.
  - When ifmap_radr_en=1 and rd_cnt==N-1: go to DRAIN with drain_start=1 in the first DRAIN cycle.
  - Exactly N enables per pass; the address generator wraps to 0 by itself, so the next OC pass rereads the same bank with no reconfiguration.
- DRAIN:
  - Wait for drain_done.
  - drain_done asserted in the same cycle as drain_start is accepted.
  - On drain_done with oc_cnt<OC1-1: oc_cnt++, rd_cnt=0, go to READ.
  - Otherwise, if tile_cnt<NTILE-1: tile_cnt++, go to WAIT_FILL.
  - Otherwise go to DONE.
- DONE (1 cycle): done=1; next state IDLE.
- busy=1 in every state except IDLE.
- Latencies:
  - start to ifmap_config_en: 1 cycle.
  - ifmap_bank_full to bank_switch: 1 cycle.
  - bank_switch to first ifmap_radr_en: 1 cycle.
  - Last read to drain_start: 1 cycle.
- stall high on the final read cycle: no count; state stays READ until the enable is actually issued.
- stall is ignored outside READ.
- drain_done outside DRAIN and ifmap_bank_full outside WAIT_FILL are ignored.
- Arithmetic unsigned; comparisons use full-width registered N.

Decomposition:
- Shared package:
  - State encoding localparams (IDLE, CONFIG, WAIT_FILL, SWITCH, READ, DRAIN, DONE).
  - Config field index/offset constants for the 10-field and 8-field buses, also used by ifmap_radr_gen's config packing.
- One sub-module: tile_loop_counter, a parameterised wrapping counter with inc/clear/last outputs, instantiated for rd_cnt, oc_cnt and tile_cnt.
- Product N computed inline.

Test Plan:
- Minimal layer: OX0=OY0=FX=FY=IC1=OC1=NTILE=1, STRIDE=1 -> exactly 1 radr_en, 1 drain_start, done 1 cycle after drain_done; busy low afterwards.
- OX0=2,OY0=2,FX=3,FY=3,IC1=2,OC1=3,NTILE=2, no stall, immediate fill/drain -> 72 enables per pass; 6 drain_start pulses; 2 bank_switch pulses; one done.
- Same config as previous scenario with stall toggling every other cycle -> still exactly 72 enables per pass; none while stall=1.
- Keep ifmap_bank_full low 20 cycles after CONFIG -> no bank_switch or radr_en until it rises; bank_switch exactly 1 cycle after.
- FX=0 with start -> cfg_err pulse; busy stays 0; no config strobe. Also: start during READ is ignored.
- Assert rst_n low mid-READ (rd_cnt=37) -> next cycle all outputs 0, state IDLE. A subsequent start then runs a complete layer with correct counts.
